spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI target (responder) for the MCU subsystem SPI master; emulates a converter-style byte register map for on-board loopback, bring-up and firmware test.
- Decodes 16-bit instruction plus streaming data bytes.
- Holds a local flop-based register file.
- Reports every completed write to fabric logic.
- Runs in the clk_clk domain; SCLK is oversampled, not used as a clock.

Parameters:
- ADDR_W, 6, register file address width; depth is 2**ADDR_W bytes.
- CHIP_ID, 8'hC1, value returned at address 0x01; this address is read-only.
- SYNC_STAGES, 2, synchroniser depth for spi_SCLK, spi_MOSI and spi_SS_n.

Ports:
- clk_clk  in  1  system clock; must be at least 8x the SCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- spi_SCLK  in  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0).
- spi_MOSI  in  1  serial data from the master.
- spi_SS_n  in  1  active-low select (one bit of the master's SS_n).
- spi_MISO  out  1  serial data to the master.
- spi_MISO_oe  out  1  MISO output enable; high only during the read data phase.
- wr_valid  out  1  one-cycle pulse per committed register write.
- wr_addr  out  ADDR_W  address of the committed write.
- wr_data  out  8  data of the committed write.
- busy  out  1  high while SS_n (synchronised) is low.

Behaviour:
- Reset values:
  - all outputs 0; spi_MISO 0; state IDLE.
  - register file all 0x00; address 0x01 reads CHIP_ID.
- Input conditioning:
  - spi_SCLK, spi_MOSI and spi_SS_n each pass through SYNC_STAGES flops.
  - A rise/fall detector on synchronised SCLK produces single-cycle sck_rise/sck_fall.
  - Mode 0 timing: sample MOSI on sck_rise; update MISO on sck_fall.
- Frame format, MSB first:
  - bit15 = R/W (1 = read); bits14:0 = start address.
  - Followed by N data bytes, N >= 0.
- Address handling:
  - Address bits above ADDR_W are "out of range": writes are dropped with no wr_valid, and reads return 0x00.
  - Address auto-increments by 1 after each data byte.
  - Increment uses the full 15 bits, so 0x7FFF wraps to 0x0000.
  - In-range addresses therefore wrap only via the full 15-bit counter.
- States:
  - IDLE: bit counter is 0. Falling edge of synchronised SS_n moves to INSTR.
  - INSTR: shift 16 bits. On the 16th sck_rise, latch rw and addr, then move to DATA.
  - DATA, write: on every 8th sck_rise, assemble the byte.
    - If in range and addr != 0x01, write regfile[addr] and pulse wr_valid on the next cycle with wr_addr/wr_data.
    - Address 0x01 writes are dropped silently.
    - Then increment addr.
  - DATA, read:
    - Load the byte at addr (combinational flop-array read) into the shift register on the sck_fall following the 16th sck_rise, and on each 8th sck_fall thereafter.
    - Shift out MSB first on each sck_fall.
    - Increment addr after each byte is loaded.
    - spi_MISO_oe = 1 from the first load until SS_n rises.
- SS_n rise in any state: return to IDLE within SYNC_STAGES+1 cycles. This is not a reset, and register contents are kept.
  - A partial instruction or partial data byte is discarded, with no write and no wr_valid.
  - spi_MISO_oe and spi_MISO go to 0.
- SCLK edges while SS_n is high are ignored.
- A new SS_n fall always restarts at INSTR bit 15.
- If a wr_valid pulse and SS_n rise coincide, the completed byte still commits.
- Asynchronous reset mid-frame clears all state and regfile immediately. The frame is lost; the next frame decodes normally only if it starts after reset release.
- Latency: SS_n/SCLK pin edge to internal action is SYNC_STAGES+1 clk_clk cycles.
- busy follows synchronised SS_n inverted.

Test Plan:
- Write 0xA5 to address 0x10 (frame 0x0010_A5) -> one wr_valid pulse with wr_addr=0x10, wr_data=0xA5; a following read of 0x10 (0x8010) shifts 0xA5 on MISO.
- Read 0x01 with 2 data bytes (frame 0x8001) -> MISO returns CHIP_ID 0xC1 then regfile[0x02] (0x00 after reset); write to 0x01 produces no wr_valid and 0x01 still reads 0xC1.
- Streaming write from 0x3F with bytes 0x11,0x22 (ADDR_W=6) -> 0x3F=0x11 with wr_valid; second byte at 0x40 is out of range, so there is no second wr_valid and regfile[0x00] stays 0x00.
- SS_n released after 5 data bits of a write to 0x05 -> no wr_valid, regfile[0x05] unchanged; the next full frame writing 0x5A to 0x05 commits correctly.
- Assert reset_reset_n low mid-read stream -> all outputs 0 within the same cycle (async); after release, regfile reads back 0x00 and 0x01 reads 0xC1.
- SCLK toggling with SS_n high, followed by a valid write frame -> no spurious writes; only the valid frame commits, and spi_MISO_oe stays 0 throughout the write.

Source files
------------

// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle plus the fabric-side write-notification port of the register responder.
`timescale 1ns/1ps
interface spi_reg_responder_if #(
  parameter int ADDR_W = 6
);
  logic              spi_SCLK;
  logic              spi_MOSI;
  logic              spi_SS_n;
  logic              spi_MISO;
  logic              spi_MISO_oe;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  // wr_valid is a push-only strobe with no ready: wr_addr/wr_data are valid only in the
  // cycle wr_valid is high, and the fabric must take them in that cycle.
  modport master (
    output spi_SCLK, spi_MOSI, spi_SS_n,
    input  spi_MISO, spi_MISO_oe, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  spi_SCLK, spi_MOSI, spi_SS_n,
    output spi_MISO, spi_MISO_oe, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/spi_reg_responder.sv
// Mode-0 SPI target with a byte register map: 16-bit instruction (R/W + 15-bit address)
// followed by streaming data bytes, SCLK oversampled in the clk_clk domain.
`timescale 1ns/1ps
module spi_reg_responder #(
  parameter int         ADDR_W      = 6,
  parameter logic [7:0] CHIP_ID     = 8'hC1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  spi_reg_responder_if.slave     bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sck_rise;
  logic                   sck_fall;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [14:0]       instr_sr;
  logic              rw;
  logic [14:0]       addr;
  logic [6:0]        rx_sr;
  logic [6:0]        tx_sr;
  logic              miso_q;
  logic              miso_oe_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic [7:0]        regfile [DEPTH];

  logic              in_range;
  logic              wr_ok;
  logic [7:0]        rd_byte;
  logic [7:0]        rx_byte;

  // SS_n synchronisers reset to the deselected (high) level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_SS_n};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_rise = sclk_s & ~sclk_q;
  assign sck_fall = ~sclk_s & sclk_q;

  // Any address bit at or above ADDR_W set means the access misses the register file.
  assign in_range = ((addr >> ADDR_W) == 15'd0);
  assign wr_ok    = in_range && (addr != 15'd1);
  assign rx_byte  = {rx_sr, mosi_s};

  always_comb begin
    rd_byte = 8'h00;
    if (in_range) begin
      rd_byte = (addr == 15'd1) ? CHIP_ID : regfile[addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      byte_cnt   <= 3'd0;
      instr_sr   <= '0;
      rw         <= 1'b0;
      addr       <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile[i] <= 8'h00;
    end else begin
      wr_valid_q <= 1'b0;
      busy_q     <= ~ss_s;
      if (ss_s) begin
        // Deselect abandons any partial instruction or byte; regfile is kept.
        state     <= IDLE;
        bit_cnt   <= 4'd0;
        byte_cnt  <= 3'd0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= INSTR;
            bit_cnt  <= 4'd0;
            byte_cnt <= 3'd0;
          end
          INSTR: begin
            if (sck_rise) begin
              instr_sr <= {instr_sr[13:0], mosi_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                rw       <= instr_sr[14];
                addr     <= {instr_sr[13:0], mosi_s};
                byte_cnt <= 3'd0;
                state    <= DATA;
              end
            end
          end
          DATA: begin
            if (rw) begin
              if (sck_fall) begin
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == 3'd0) begin
                  miso_q    <= rd_byte[7];
                  tx_sr     <= rd_byte[6:0];
                  miso_oe_q <= 1'b1;
                  addr      <= addr + 15'd1;
                end else begin
                  miso_q <= tx_sr[6];
                  tx_sr  <= {tx_sr[5:0], 1'b0};
                end
              end
            end else if (sck_rise) begin
              rx_sr    <= {rx_sr[5:0], mosi_s};
              byte_cnt <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd7) begin
                if (wr_ok) begin
                  regfile[addr[ADDR_W-1:0]] <= rx_byte;
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr[ADDR_W-1:0];
                  wr_data_q  <= rx_byte;
                end
                addr <= addr + 15'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.spi_MISO    = miso_q;
  assign bus.spi_MISO_oe = miso_oe_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = busy_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed and random SPI frames against a byte-array model.
`timescale 1ns/1ps
module tb_spi_reg_responder;

  localparam int         ADDR_W  = 6;
  localparam int         DEPTH   = 64;
  localparam logic [7:0] CHIP_ID = 8'hC1;
  localparam int         HALF    = 80;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [1:0] state_dbg;

  spi_reg_responder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_responder #(.ADDR_W(ADDR_W), .CHIP_ID(CHIP_ID), .SYNC_STAGES(2)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        tx_q[$];
  logic [7:0]        rx_q[$];
  logic [7:0]        model_mem [DEPTH];
  logic              write_frame = 1'b0;
  int                oe_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_read(input logic [14:0] a);
    if (a >= 15'(DEPTH)) return 8'h00;
    if (a == 15'd1) return CHIP_ID;
    return model_mem[a[ADDR_W-1:0]];
  endfunction

  task automatic model_write(input logic [14:0] a, input logic [7:0] d);
    if (a < 15'(DEPTH) && a != 15'd1) begin
      model_mem[a[ADDR_W-1:0]] = d;
      exp_q.push_back({a[ADDR_W-1:0], d});
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk_clk) begin
    if (bus.wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_spurious", {bus.wr_addr, bus.wr_data}, 32'h0);
      end else begin
        check("wr_commit", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end
    end
    if (write_frame && bus.spi_MISO_oe === 1'b1) oe_viol++;
  end

  // ---------------- driver tasks ----------------
  task automatic sck_bit(input logic b, output logic r);
    bus.spi_MOSI = b;
    #(HALF);
    bus.spi_SCLK = 1'b1;
    r = bus.spi_MISO;
    #(HALF);
    bus.spi_SCLK = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] instr, input int nbytes, input int extra_bits);
    logic r;
    logic [7:0] rb;
    rx_q.delete();
    bus.spi_SS_n = 1'b0;
    #(HALF);
    check("busy_active", bus.busy, 1);
    for (int i = 15; i >= 0; i--) sck_bit(instr[i], r);
    for (int k = 0; k < nbytes; k++) begin
      rb = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        sck_bit(tx_q[k][i], r);
        rb = {rb[6:0], r};
      end
      rx_q.push_back(rb);
    end
    for (int i = 0; i < extra_bits; i++) sck_bit(tx_q[nbytes][7-i], r);
    if (instr[15] && nbytes > 0) check("oe_read", bus.spi_MISO_oe, 1);
    #(HALF);
    bus.spi_SS_n = 1'b1;
    #(2*HALF);
    check("oe_idle", bus.spi_MISO_oe, 0);
    check("miso_idle", bus.spi_MISO, 0);
    check("busy_idle", bus.busy, 0);
    check("state_idle", state_dbg, 0);
  endtask

  // Caller fills tx_q with at least n+1 bytes; the last one supplies any partial bits.
  task automatic do_write(input logic [14:0] a, input int n, input int extra);
    logic [14:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      model_write(p, tx_q[i]);
      p = p + 15'd1;
    end
    oe_viol = 0;
    write_frame = 1'b1;
    spi_frame({1'b0, a}, n, extra);
    write_frame = 1'b0;
    check("oe_write", oe_viol, 0);
    check("wr_missing", exp_q.size(), 0);
  endtask

  task automatic do_read(input logic [14:0] a, input int n);
    logic [7:0] exp_b[$];
    logic [14:0] p;
    p = a;
    tx_q.delete();
    for (int i = 0; i <= n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n; i++) begin
      exp_b.push_back(model_read(p));
      p = p + 15'd1;
    end
    spi_frame({1'b1, a}, n, 0);
    for (int i = 0; i < n; i++) check("rd_byte", rx_q[i], exp_b[i]);
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    tx_q.delete();
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r;
    logic [14:0] a;
    int n;
    int extra;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    reset_reset_n = 1'b0;
    bus.spi_SCLK  = 1'b0;
    bus.spi_MOSI  = 1'b0;
    bus.spi_SS_n  = 1'b1;
    #12;
    check("rst_miso", bus.spi_MISO, 0);
    check("rst_oe", bus.spi_MISO_oe, 0);
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr_data", {bus.wr_addr, bus.wr_data}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", state_dbg, 0);
    #18;
    reset_reset_n = 1'b1;
    #40;

    // Basic write then readback.
    set_tx(8'hA5, 8'h00, 8'h00);
    do_write(15'h0010, 1, 0);
    do_read(15'h0010, 1);

    // Chip ID, read-only address and the byte after it.
    do_read(15'h0001, 2);
    set_tx(8'h77, 8'h00, 8'h00);
    do_write(15'h0001, 1, 0);
    do_read(15'h0001, 1);

    // Stream across the top of the map: second byte is out of range.
    set_tx(8'h11, 8'h22, 8'h00);
    do_write(15'h003F, 2, 0);
    do_read(15'h003F, 1);
    do_read(15'h0000, 1);

    // Deselect after 5 data bits, then a full frame to the same address.
    set_tx(8'hFF, 8'hFF, 8'h00);
    do_write(15'h0005, 0, 5);
    do_read(15'h0005, 1);
    set_tx(8'h5A, 8'h00, 8'h00);
    do_write(15'h0005, 1, 0);
    do_read(15'h0005, 1);

    // SCLK activity while deselected must be ignored.
    for (int i = 0; i < 20; i++) begin
      bus.spi_MOSI = 1'($urandom_range(0, 1));
      #(HALF);
      bus.spi_SCLK = ~bus.spi_SCLK;
    end
    bus.spi_SCLK = 1'b0;
    #(HALF);
    check("desel_busy", bus.busy, 0);
    check("desel_state", state_dbg, 0);
    set_tx(8'h3C, 8'h00, 8'h00);
    do_write(15'h0020, 1, 0);
    do_read(15'h0020, 1);

    // 15-bit address wrap: 0x7FFF is dropped, the following byte lands at 0x0000.
    set_tx(8'hE1, 8'hE2, 8'h00);
    do_write(15'h7FFF, 2, 0);
    do_read(15'h7FFF, 2);

    // Randomised frames mixing in-range, boundary and out-of-range addresses.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0: a = 15'($urandom_range(0, DEPTH - 1));
        1: a = 15'($urandom_range(DEPTH - 2, DEPTH - 1));
        2: a = 15'($urandom_range(DEPTH, 15'h7FFF));
        default: a = 15'($urandom_range(15'h7FFE, 15'h7FFF));
      endcase
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        tx_q.delete();
        for (int i = 0; i <= n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        do_write(a, n, extra);
      end else begin
        do_read(a, n);
      end
    end

    // Asynchronous reset in the middle of a read stream.
    bus.spi_SS_n = 1'b0;
    #(HALF);
    for (int i = 15; i >= 0; i--) sck_bit(((16'h8010 >> i) & 16'h1) != 0, r);
    for (int i = 0; i < 3; i++) sck_bit(1'b0, r);
    reset_reset_n = 1'b0;
    #1;
    check("arst_miso", bus.spi_MISO, 0);
    check("arst_oe", bus.spi_MISO_oe, 0);
    check("arst_wr_valid", bus.wr_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_state", state_dbg, 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    exp_q.delete();
    #(HALF);
    bus.spi_SS_n = 1'b1;
    #(HALF);
    reset_reset_n = 1'b1;
    #(2*HALF);
    do_read(15'h0000, 3);
    do_read(15'h0010, 1);
    do_read(15'h003F, 1);

    check("wr_pending_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
